// File: rtl/fetch_unit.sv
// Fetch unit: owns PC and IR, executes controller PC commands and fetches
// instruction words over a req/ack memory handshake with a timeout watchdog.
module fetch_unit #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PC_RST,
    input  logic              PC_WRITE,
    input  logic              PC_SEL,
    input  logic              BR_SEL,
    input  logic              FETCH_EN,
    output logic              IMEM_REQ,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    input  logic              IMEM_ACK,
    input  logic [DATA_W-1:0] IMEM_RDATA,
    output logic [3:0]        OPCODE,
    output logic [3:0]        MM,
    output logic [15:0]       IMM,
    output logic [ADDR_W-1:0] PC_OUT,
    output logic              IR_VALID,
    output logic              BUSY,
    output logic              FETCH_ERR
);

    localparam int EXT_W = (ADDR_W > 16) ? ADDR_W : 16;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  ir;
    logic               err;
    logic               start;
    logic               ack_take;
    logic               timeout_hit;
    logic               unused_ir;

    // Relative branch: sign-extend the 16-bit offset, wrap modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] branch_rel(input logic [ADDR_W-1:0] base,
                                                      input logic signed [15:0] ofs);
        logic signed [EXT_W-1:0] ofs_ext;
        ofs_ext = EXT_W'(ofs);
        return base + ofs_ext[ADDR_W-1:0];
    endfunction

    // Absolute branch: zero-extend (or truncate) the immediate to ADDR_W.
    function automatic logic [ADDR_W-1:0] branch_abs(input logic [15:0] imm);
        logic [EXT_W-1:0] imm_ext;
        imm_ext = EXT_W'(imm);
        return imm_ext[ADDR_W-1:0];
    endfunction

    always_comb begin
        state_nxt   = state;
        start       = 1'b0;
        ack_take    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (FETCH_EN) begin
                    state_nxt = REQ;
                    start     = 1'b1;
                end
            end
            REQ: begin
                // An ack on the final watchdog cycle still wins over the timeout.
                if (IMEM_ACK) begin
                    state_nxt = DONE;
                    ack_take  = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = IDLE;
                    timeout_hit = 1'b1;
                end
            end
            DONE: begin
                if (FETCH_EN) begin
                    state_nxt = REQ;
                    start     = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            addr  <= '0;
            ir    <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= timeout_hit;
            if (start) begin
                addr <= pc;
                cnt  <= '0;
            end else if (state == REQ) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (ack_take) begin
                ir <= IMEM_RDATA;
            end else if (timeout_hit) begin
                ir <= '0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc <= '0;
        end else if (PC_RST) begin
            pc <= '0;
        end else if (PC_WRITE) begin
            if (!PC_SEL) begin
                pc <= pc + ADDR_W'(1);
            end else if (!BR_SEL) begin
                pc <= branch_rel(pc, ir[15:0]);
            end else begin
                pc <= branch_abs(ir[15:0]);
            end
        end
    end

    assign IMEM_REQ  = (state == REQ);
    assign BUSY      = (state == REQ);
    assign IR_VALID  = (state == DONE);
    assign FETCH_ERR = err;
    assign IMEM_ADDR = addr;
    assign PC_OUT    = pc;
    assign OPCODE    = ir[DATA_W-1:DATA_W-4];
    assign MM        = ir[DATA_W-5:DATA_W-8];
    assign IMM       = ir[15:0];
    assign unused_ir = ^ir[DATA_W-9:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: PC command table plus hand-written fetch,
// timeout and reset sequences.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        PC_RST = 1'b0;
    logic        PC_WRITE = 1'b0;
    logic        PC_SEL = 1'b0;
    logic        BR_SEL = 1'b0;
    logic        FETCH_EN = 1'b0;
    logic        IMEM_REQ;
    logic [15:0] IMEM_ADDR;
    logic        IMEM_ACK = 1'b0;
    logic [31:0] IMEM_RDATA = 32'h0;
    logic [3:0]  OPCODE;
    logic [3:0]  MM;
    logic [15:0] IMM;
    logic [15:0] PC_OUT;
    logic        IR_VALID;
    logic        BUSY;
    logic        FETCH_ERR;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(15)) dut (
        .CLK(CLK), .RST(RST), .PC_RST(PC_RST), .PC_WRITE(PC_WRITE),
        .PC_SEL(PC_SEL), .BR_SEL(BR_SEL), .FETCH_EN(FETCH_EN),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK),
        .IMEM_RDATA(IMEM_RDATA), .OPCODE(OPCODE), .MM(MM), .IMM(IMM),
        .PC_OUT(PC_OUT), .IR_VALID(IR_VALID), .BUSY(BUSY), .FETCH_ERR(FETCH_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        load_ir;
        logic [31:0] word;
        logic        pc_rst;
        logic        pc_write;
        logic        pc_sel;
        logic        br_sel;
        logic [15:0] exp_pc;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Strobe a fetch and ack it on the first REQ cycle; leaves the unit in IDLE.
    task automatic do_fetch(input logic [31:0] word);
        FETCH_EN = 1'b1;
        tick();
        FETCH_EN   = 1'b0;
        IMEM_ACK   = 1'b1;
        IMEM_RDATA = word;
        tick();
        IMEM_ACK = 1'b0;
        tick();
    endtask

    initial begin
        int req_cnt;
        int err_cnt;
        int vld_cnt;

        vecs[0]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 16'h0001};
        vecs[1]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 16'h0002};
        vecs[2]  = '{1'b1, 32'h1000_FFFC, 1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFE};
        vecs[3]  = '{1'b1, 32'h2000_0040, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0040};
        vecs[4]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 16'h0040};
        vecs[5]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 16'h0080};
        vecs[6]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 16'h0000};
        vecs[7]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 16'h0040};
        vecs[8]  = '{1'b1, 32'h3000_FFFF, 1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFF};
        vecs[9]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[10] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[11] = '{1'b1, 32'h4000_0005, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0005};

        // Reset state
        #1;
        check("rst_pc", 32'(PC_OUT), 32'h0);
        check("rst_req", 32'(IMEM_REQ), 32'h0);
        check("rst_opcode", 32'(OPCODE), 32'h0);
        check("rst_busy", 32'(BUSY), 32'h0);
        check("rst_irvalid", 32'(IR_VALID), 32'h0);
        check("rst_err", 32'(FETCH_ERR), 32'h0);
        tick();
        tick();
        RST = 1'b0;

        // Increment three times, start a fetch on the last, then async reset mid-cycle
        PC_WRITE = 1'b1;
        tick();
        check("inc1", 32'(PC_OUT), 32'h1);
        tick();
        check("inc2", 32'(PC_OUT), 32'h2);
        FETCH_EN = 1'b1;
        tick();
        check("inc3", 32'(PC_OUT), 32'h3);
        check("pre_rst_req", 32'(IMEM_REQ), 32'h1);
        PC_WRITE = 1'b0;
        FETCH_EN = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        check("async_rst_pc", 32'(PC_OUT), 32'h0);
        check("async_rst_req", 32'(IMEM_REQ), 32'h0);
        check("async_rst_busy", 32'(BUSY), 32'h0);
        #1;
        RST = 1'b0;
        tick();
        check("post_rst_req", 32'(IMEM_REQ), 32'h0);

        // PC command table
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].load_ir) do_fetch(vecs[i].word);
            PC_RST   = vecs[i].pc_rst;
            PC_WRITE = vecs[i].pc_write;
            PC_SEL   = vecs[i].pc_sel;
            BR_SEL   = vecs[i].br_sel;
            tick();
            PC_RST   = 1'b0;
            PC_WRITE = 1'b0;
            PC_SEL   = 1'b0;
            BR_SEL   = 1'b0;
            check($sformatf("pc_vec%0d", i), 32'(PC_OUT), 32'(vecs[i].exp_pc));
        end

        // Fetch at PC=5, ack on second REQ cycle, PC increments while pending
        FETCH_EN = 1'b1;
        tick();
        FETCH_EN = 1'b0;
        check("f_req", 32'(IMEM_REQ), 32'h1);
        check("f_busy", 32'(BUSY), 32'h1);
        check("f_addr0", 32'(IMEM_ADDR), 32'h5);
        PC_WRITE = 1'b1;
        tick();
        PC_WRITE = 1'b0;
        check("f_pc_moves", 32'(PC_OUT), 32'h6);
        check("f_addr1", 32'(IMEM_ADDR), 32'h5);
        check("f_req1", 32'(IMEM_REQ), 32'h1);
        check("f_novalid", 32'(IR_VALID), 32'h0);
        IMEM_ACK   = 1'b1;
        IMEM_RDATA = 32'h8A00_0003;
        tick();
        IMEM_ACK = 1'b0;
        check("f_valid", 32'(IR_VALID), 32'h1);
        check("f_opcode", 32'(OPCODE), 32'h8);
        check("f_mm", 32'(MM), 32'hA);
        check("f_imm", 32'(IMM), 32'h0003);
        check("f_req_drop", 32'(IMEM_REQ), 32'h0);
        check("f_busy_drop", 32'(BUSY), 32'h0);
        tick();
        check("f_valid_pulse", 32'(IR_VALID), 32'h0);
        check("f_busy_after", 32'(BUSY), 32'h0);

        // Stray ack in IDLE is ignored
        IMEM_ACK   = 1'b1;
        IMEM_RDATA = 32'hF000_0000;
        tick();
        IMEM_ACK = 1'b0;
        check("stray_valid", 32'(IR_VALID), 32'h0);
        check("stray_opcode", 32'(OPCODE), 32'h8);

        // No ack: watchdog expires after 15 REQ cycles
        req_cnt = 0; err_cnt = 0; vld_cnt = 0;
        FETCH_EN = 1'b1;
        tick();
        FETCH_EN = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (IMEM_REQ) req_cnt++;
            if (FETCH_ERR) err_cnt++;
            if (IR_VALID) vld_cnt++;
            tick();
        end
        check("to_req_cycles", 32'(req_cnt), 32'd15);
        check("to_err_pulses", 32'(err_cnt), 32'd1);
        check("to_no_valid", 32'(vld_cnt), 32'd0);
        check("to_opcode", 32'(OPCODE), 32'h0);

        // Ack on the 15th REQ cycle; extra strobe during REQ is dropped
        req_cnt = 0; err_cnt = 0; vld_cnt = 0;
        IMEM_RDATA = 32'h5C00_1234;
        FETCH_EN = 1'b1;
        tick();
        FETCH_EN = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (IMEM_REQ) req_cnt++;
            if (FETCH_ERR) err_cnt++;
            if (IR_VALID) vld_cnt++;
            IMEM_ACK = IMEM_REQ && (req_cnt == 15);
            FETCH_EN = IMEM_REQ && (req_cnt == 3);
            tick();
        end
        IMEM_ACK = 1'b0;
        FETCH_EN = 1'b0;
        check("late_req_cycles", 32'(req_cnt), 32'd15);
        check("late_no_err", 32'(err_cnt), 32'd0);
        check("late_valid", 32'(vld_cnt), 32'd1);
        check("late_opcode", 32'(OPCODE), 32'h5);
        check("late_mm", 32'(MM), 32'hC);
        check("late_imm", 32'(IMM), 32'h1234);

        // FETCH_EN in DONE starts the next fetch immediately
        FETCH_EN = 1'b1;
        tick();
        FETCH_EN   = 1'b0;
        IMEM_ACK   = 1'b1;
        IMEM_RDATA = 32'h6100_0007;
        tick();
        IMEM_ACK = 1'b0;
        check("b2b_valid", 32'(IR_VALID), 32'h1);
        FETCH_EN = 1'b1;
        tick();
        FETCH_EN = 1'b0;
        check("b2b_req", 32'(IMEM_REQ), 32'h1);
        check("b2b_addr", 32'(IMEM_ADDR), 32'(PC_OUT));
        IMEM_ACK   = 1'b1;
        IMEM_RDATA = 32'h7200_0009;
        tick();
        IMEM_ACK = 1'b0;
        check("b2b_opcode", 32'(OPCODE), 32'h7);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
